// File: rtl/sha2_pkg.sv
// SHA-2 shared constants, round helper functions and engine state encoding.
package sha2_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  // Working variables a..h; a occupies the MSBs so H0..H7 casts map H0 onto a.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sha2_state_t;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: a..h, K[t], W[t] -> next a..h.
module sha2_round
  import sha2_pkg::*;
(
  input  sha2_state_t i_state,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output sha2_state_t o_state
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;

  assign w_t1 = i_state.h + big_sigma1(i_state.e) + ch(i_state.e, i_state.f, i_state.g)
              + i_k + i_w;
  assign w_t2 = big_sigma0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

  always_comb begin
    o_state   = i_state;
    o_state.a = w_t1 + w_t2;
    o_state.b = i_state.a;
    o_state.c = i_state.b;
    o_state.d = i_state.c;
    o_state.e = i_state.d + w_t1;
    o_state.f = i_state.e;
    o_state.g = i_state.f;
    o_state.h = i_state.g;
  end

endmodule

// File: rtl/sha2_block_engine.sv
// Iterative SHA-256/224 block engine, UNROLL rounds per clock, chained blocks.
// Optional SHA2_SELFCLEAR_EN zeroizes chaining state and digest after each handshake.
module sha2_block_engine
  import sha2_pkg::*;
#(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned BLK_W  = 512,
  parameter int unsigned DIG_W  = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic             mode,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [DIG_W-1:0] digest,
  output logic             busy
);

  state_e          r_state;
  sha2_state_t     r_work;
  logic [255:0]    r_h;
  logic [0:15][31:0] r_w;
  logic [5:0]      r_t;
  logic            r_mode;
  logic            r_last;
  logic            r_dig_valid;
  logic [255:0]    r_digest;

  logic [0:15][31:0] w_w_next;
  sha2_state_t       w_rounds_out;
  logic [255:0]      w_work_flat;
  logic [255:0]      w_h_sum;
  logic [255:0]      w_iv;

  // Extend the schedule by UNROLL words; later words may depend on earlier new ones.
  always_comb begin
    logic [31:0] ext [16+UNROLL];
    for (int i = 0; i < 16; i++) ext[i] = r_w[i];
    for (int j = 0; j < int'(UNROLL); j++) begin
      ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
    end
    w_w_next = '0;
    for (int i = 0; i < 16; i++) w_w_next[i] = ext[i+UNROLL];
  end

  for (genvar j = 0; j < int'(UNROLL); j++) begin : g_rnd
    sha2_state_t w_in;
    sha2_state_t w_next;
    if (j == 0) begin : g_head
      assign w_in = r_work;
    end else begin : g_link
      assign w_in = g_rnd[j-1].w_next;
    end
    sha2_round u_round (
      .i_state (w_in),
      .i_k     (K[r_t + 6'(j)]),
      .i_w     (r_w[j]),
      .o_state (w_next)
    );
  end

  assign w_rounds_out = g_rnd[UNROLL-1].w_next;
  assign w_work_flat  = r_work;
  assign w_iv         = mode ? IV224 : IV256;

  always_comb begin
    w_h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_h_sum[i*32 +: 32] = r_h[i*32 +: 32] + w_work_flat[i*32 +: 32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_work      <= IV256;
      r_h         <= IV256;
      r_w         <= '0;
      r_t         <= '0;
      r_mode      <= 1'b0;
      r_last      <= 1'b0;
      r_dig_valid <= 1'b0;
      r_digest    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (blk_valid) begin
            r_w    <= blk_data[511:0];
            r_last <= blk_last;
            r_t    <= '0;
            if (blk_first) begin
              r_mode <= mode;
              r_h    <= w_iv;
              r_work <= w_iv;
            end else begin
              r_work <= r_h;
            end
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_work <= w_rounds_out;
          r_w    <= w_w_next;
          r_t    <= r_t + 6'(UNROLL);
          if (r_t == 6'(64 - UNROLL)) r_state <= FINAL;
        end
        FINAL: begin
          r_h <= w_h_sum;
          if (r_last) begin
            r_digest    <= r_mode ? {w_h_sum[255:32], 32'h0} : w_h_sum;
            r_dig_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          if (dig_ready) begin
            r_dig_valid <= 1'b0;
            r_state     <= IDLE;
`ifdef SHA2_SELFCLEAR_EN
            r_h      <= '0;
            r_work   <= '0;
            r_w      <= '0;
            r_digest <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign blk_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign dig_valid = r_dig_valid;
  assign digest    = r_digest[DIG_W-1:0];

endmodule

// File: tb/tb_sha2_block_engine.sv
// Directed, table-driven bench for sha2_block_engine (known SHA-256/224 vectors).
module tb_sha2_block_engine;

  parameter int unsigned UNROLL = 1;
  localparam int N = 64 / UNROLL;

  logic         clock;
  logic         reset;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         mode;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] digest;
  logic         busy;

  int total = 0;
  int bad   = 0;

  sha2_block_engine #(.UNROLL(UNROLL)) dut (
    .clock     (clock),
    .reset     (reset),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .mode      (mode),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic         mode;
    logic [255:0] dig;
  } vec_t;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_M1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_ABC224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] DIG_TWO256 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    blk_data  = v.data;
    blk_first = v.first;
    blk_last  = v.last;
    mode      = v.mode;
    blk_valid = 1'b1;
  endtask

  // Called on a negedge with blk_valid high; returns on the negedge after acceptance.
  task automatic wait_accept(input string nm);
    int cnt = 0;
    while (!blk_ready && cnt < 300) begin
      @(negedge clock);
      cnt++;
    end
    if (cnt >= 300) chk({nm, "_accept_timeout"}, 1, 0);
    @(posedge clock);
    @(negedge clock);
    blk_valid = 1'b0;
    chk({nm, "_busy_after_accept"}, busy, 1);
  endtask

  task automatic wait_result(input string nm, input vec_t v);
    int   cnt  = 0;
    logic seen = 1'b0;
    if (v.last) begin
      while (!dig_valid && cnt < 300) begin
        @(negedge clock);
        cnt++;
      end
      chk({nm, "_latency"}, cnt, N + 1);
      chk({nm, "_digest"}, digest, v.dig);
      chk({nm, "_busy_done"}, busy, 1);
      chk({nm, "_ready_done"}, blk_ready, 0);
    end else begin
      while (!blk_ready && cnt < 300) begin
        @(negedge clock);
        cnt++;
        if (dig_valid) seen = 1'b1;
      end
      chk({nm, "_throughput"}, cnt, N + 1);
      chk({nm, "_no_digest"}, seen, 0);
    end
  endtask

  task automatic handshake(input string nm, input logic [255:0] prev);
    dig_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dig_ready = 1'b0;
    chk({nm, "_valid_cleared"}, dig_valid, 0);
    chk({nm, "_ready_after_hs"}, blk_ready, 1);
`ifdef SHA2_SELFCLEAR_EN
    chk({nm, "_digest_cleared"}, digest, 256'h0);
`else
    chk({nm, "_digest_held"}, digest, prev);
`endif
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [255:0] held;
    logic seen;

    tbl[0] = '{data: BLK_ABC, first: 1'b1, last: 1'b1, mode: 1'b0, dig: DIG_ABC256};
    tbl[1] = '{data: BLK_ABC, first: 1'b1, last: 1'b1, mode: 1'b1, dig: DIG_ABC224};
    tbl[2] = '{data: BLK_M1,  first: 1'b1, last: 1'b0, mode: 1'b0, dig: 256'h0};
    // Mode set on a continuation block must be ignored.
    tbl[3] = '{data: BLK_M2,  first: 1'b0, last: 1'b1, mode: 1'b1, dig: DIG_TWO256};

    reset     = 1'b1;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    mode      = 1'b0;
    dig_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_digest", digest, 256'h0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_ready", blk_ready, 1);
    reset = 1'b0;

    // Stray dig_ready while idle does nothing.
    dig_ready = 1'b1;
    repeat (3) @(negedge clock);
    dig_ready = 1'b0;
    chk("stray_ready_valid", dig_valid, 0);
    chk("stray_ready_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      @(negedge clock);
      drive(tbl[i]);
      wait_accept(nm);
      wait_result(nm, tbl[i]);
      if (tbl[i].last) handshake(nm, tbl[i].dig);
    end

    // Back-pressure: digest waits 10 cycles with the next block already offered.
    @(negedge clock);
    drive(tbl[0]);
    wait_accept("stall_a");
    wait_result("stall_a", tbl[0]);
    drive(tbl[1]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk($sformatf("stall_digest%0d", c), digest, DIG_ABC256);
      chk($sformatf("stall_ready%0d", c), blk_ready, 0);
      chk($sformatf("stall_valid%0d", c), dig_valid, 1);
    end
    handshake("stall_hs", DIG_ABC256);
    @(posedge clock);
    @(negedge clock);
    blk_valid = 1'b0;
    chk("stall_next_accepted", busy, 1);
    wait_result("stall_b", tbl[1]);
    handshake("stall_b", DIG_ABC224);

    // Reset in the middle of the rounds aborts without a digest.
    @(negedge clock);
    drive(tbl[0]);
    wait_accept("abort");
    repeat (N / 2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_valid", dig_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_digest", digest, 256'h0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (N + 5) begin
      @(negedge clock);
      if (dig_valid) seen = 1'b1;
    end
    chk("abort_no_digest", seen, 0);

    // Continuation block straight after reset chains from the SHA-256 IV.
    v = tbl[0];
    v.first = 1'b0;
    drive(v);
    wait_accept("chain_iv");
    wait_result("chain_iv", v);
    handshake("chain_iv", DIG_ABC256);

    do_reset();
    @(negedge clock);
    drive(tbl[0]);
    wait_accept("resend");
    wait_result("resend", tbl[0]);
    held = digest;
    handshake("resend", held);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
